// File: rtl/lcd_inst_pkg.sv
// HD44780 instruction codes and controller state type
// shared by the LCD Avalon controller and its timer.
package lcd_inst_pkg;

  localparam logic [7:0] CLEAR_DISPLAY = 8'h01;
  localparam logic [7:0] RETURN_HOME   = 8'h02;
  localparam logic [7:0] ENTRY_MODE    = 8'h06;
  localparam logic [7:0] DISPLAY_ON    = 8'h0C;
  localparam logic [7:0] FUNCTION_SET  = 8'h38;

  typedef enum logic [2:0] {
    POWERUP,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_ctrl_state_t;

  // Clear and return-home need the long execution wait.
  function automatic logic is_slow_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data[7:2] == 6'd0);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by all timed controller
// states; done flags a count of zero.
module lcd_timer #(
  parameter int           W       = 20,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on state entry, otherwise count down to zero and stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_avalon_ctrl.sv
// Avalon-MM slave driving an HD44780 character LCD with
// setup/enable/hold/exec timing and autonomous power-up init.
module lcd_avalon_ctrl #(
  parameter int SETUP_CYC   = 4,
  parameter int EN_CYC      = 12,
  parameter int HOLD_CYC    = 4,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int POWERUP_CYC = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       address,
  input  logic       chipselect,
  input  logic       byteenable,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic [1:0] response,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_blon
);

  import lcd_inst_pkg::*;

  localparam int MAXC = max_of(
    max_of(max_of(SETUP_CYC, EN_CYC),
           max_of(HOLD_CYC, EXEC_CYC)),
    max_of(CLEAR_CYC, POWERUP_CYC));
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [7:0] INIT_ROM [4] = '{
    FUNCTION_SET, DISPLAY_ON, ENTRY_MODE, CLEAR_DISPLAY
  };

  lcd_ctrl_state_t state, next_state;

  logic          tmr_load;
  logic [CW-1:0] tmr_value;
  logic          tmr_done;
  logic          idle;
  logic          accept;
  logic          init_done;
  logic [1:0]    init_idx;

  assign idle   = (state == IDLE);
  assign accept = idle && chipselect && write
                  && !read && byteenable;

  lcd_timer #(
    .W       (CW),
    .RST_VAL (CW'(POWERUP_CYC - 1))
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= POWERUP;
    else       state <= next_state;
  end

  // Next state and timer reload on every state entry.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    unique case (state)
      POWERUP: begin
        if (tmr_done) begin
          next_state = SETUP;
          tmr_load   = 1'b1;
          tmr_value  = CW'(SETUP_CYC - 1);
        end
      end
      IDLE: begin
        if (accept) begin
          next_state = SETUP;
          tmr_load   = 1'b1;
          tmr_value  = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (tmr_done) begin
          next_state = PULSE;
          tmr_load   = 1'b1;
          tmr_value  = CW'(EN_CYC - 1);
        end
      end
      PULSE: begin
        if (tmr_done) begin
          next_state = HOLD;
          tmr_load   = 1'b1;
          tmr_value  = CW'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (tmr_done) begin
          next_state = EXEC;
          tmr_load   = 1'b1;
          tmr_value  = is_slow_cmd(lcd_rs, lcd_data)
                       ? CW'(CLEAR_CYC - 1)
                       : CW'(EXEC_CYC - 1);
        end
      end
      EXEC: begin
        if (tmr_done) begin
          if (!init_done && init_idx != 2'd3) begin
            next_state = SETUP;
            tmr_load   = 1'b1;
            tmr_value  = CW'(SETUP_CYC - 1);
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = POWERUP;
    endcase
  end

  // LCD bus latches and init sequencing progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      init_done <= 1'b0;
      init_idx  <= 2'd0;
    end else begin
      if (state == POWERUP && tmr_done) begin
        lcd_rs   <= 1'b0;
        lcd_data <= INIT_ROM[0];
      end
      if (accept) begin
        lcd_rs   <= address;
        lcd_data <= writedata;
      end
      if (state == EXEC && tmr_done && !init_done) begin
        if (init_idx == 2'd3) begin
          init_done <= 1'b1;
        end else begin
          init_idx <= init_idx + 2'd1;
          lcd_rs   <= 1'b0;
          lcd_data <= INIT_ROM[init_idx + 2'd1];
        end
      end
    end
  end

  // Bus handshake, status reads and enable strobe.
  always_comb begin
    waitrequest = !idle;
    lcd_en      = (state == PULSE);
    readdata    = 8'h00;
    response    = 2'b00;
    if (idle && chipselect && read) begin
      if (write || address) begin
        response = 2'b10;
      end else begin
        readdata = {7'b0, init_done};
      end
    end
  end

  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;

endmodule

// File: tb/tb_lcd_avalon_ctrl.sv
// Directed and randomized bench for lcd_avalon_ctrl with
// a pulse-level reference model of the LCD bus.
module tb_lcd_avalon_ctrl;

  localparam int S = 2;
  localparam int E = 3;
  localparam int H = 2;
  localparam int X = 5;
  localparam int C = 20;
  localparam int P = 10;

  typedef struct {
    bit         rs;
    logic [7:0] data;
    int         width;
    int         start;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;
  logic [1:0] response;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;
  logic       lcd_blon;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_acc;
  int last_busy;

  pulse_t mon_q[$];
  pulse_t exp_q[$];

  int         mw = 0;
  int         mst;
  bit         mrs;
  logic [7:0] mdata;

  lcd_avalon_ctrl #(
    .SETUP_CYC   (S),
    .EN_CYC      (E),
    .HOLD_CYC    (H),
    .EXEC_CYC    (X),
    .CLEAR_CYC   (C),
    .POWERUP_CYC (P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .response    (response),
    .lcd_data    (lcd_data),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .lcd_on      (lcd_on),
    .lcd_blon    (lcd_blon)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: one record per completed enable pulse.
  always @(negedge clk) begin
    if (reset) begin
      mw <= 0;
    end else if (lcd_en) begin
      if (mw == 0) begin
        mst   <= cyc;
        mrs   <= lcd_rs;
        mdata <= lcd_data;
      end
      mw <= mw + 1;
    end else if (mw != 0) begin
      mon_q.push_back('{mrs, mdata, mw, mst});
      mw <= 0;
    end
  end

  function automatic int busy(bit rs, logic [7:0] d);
    return S + E + H + ((!rs && d < 4) ? C : X);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic wait_idle(output int t);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!waitrequest) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("idle_reached", ok, 1);
    t = cyc;
  endtask

  task automatic do_write(input bit a,
                          input logic [7:0] d,
                          input bit chk_gap);
    bit ok = 0;
    int n;
    chipselect = 1; write = 1; read = 0;
    byteenable = 1; address = a; writedata = d;
    for (int i = 0; i < 300; i++) begin
      if (!waitrequest) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chipselect = 0; write = 0;
    chk("accept", ok, 1);
    chk("busy_after_accept", waitrequest, 1);
    n = cyc;
    if (chk_gap)
      chk("b2b_gap", n - last_acc, last_busy + 1);
    exp_q.push_back('{a, d, E, n + S});
    last_acc  = n;
    last_busy = busy(a, d);
  endtask

  task automatic check_pulses();
    pulse_t m, x;
    chk("pulse_count", mon_q.size(), exp_q.size());
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      m = mon_q.pop_front();
      x = exp_q.pop_front();
      chk("pulse_rs", m.rs, x.rs);
      chk("pulse_data", m.data, x.data);
      chk("pulse_width", m.width, x.width);
      chk("pulse_start", m.start, x.start);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic run_init(input int r);
    logic [7:0] rom [4];
    int e, t;
    rom = '{8'h38, 8'h0C, 8'h06, 8'h01};
    e = r + P;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{1'b0, rom[i], E, e + S});
      e += busy(1'b0, rom[i]);
    end
    wait_idle(t);
    chk("init_idle_cycle", t, e);
    check_pulses();
    chipselect = 1; read = 1; address = 0;
    #1;
    chk("status_init_done", readdata, 8'h01);
    chk("status_resp", response, 2'b00);
    chipselect = 0; read = 0;
  endtask

  initial begin
    int t, r;
    bit ok;
    bit a;
    logic [7:0] d;

    reset = 1; address = 0; chipselect = 0;
    byteenable = 1; read = 0; write = 0;
    writedata = 8'h00;

    @(posedge clk); #1;
    chk("rst_waitreq", waitrequest, 1);
    chk("rst_en", lcd_en, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_readdata", readdata, 8'h00);
    chk("rst_resp", response, 2'b00);
    chk("rw_const", {lcd_rw, lcd_on, lcd_blon}, 3'b011);

    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    r = cyc;
    run_init(r);

    // Directed data write and clear.
    do_write(1'b1, 8'h45, 1'b0);
    chk("rs_latched", lcd_rs, 1);
    chk("data_latched", lcd_data, 8'h45);
    wait_idle(t);
    chk("busy_data", t - last_acc, 12);
    do_write(1'b0, 8'h01, 1'b0);
    wait_idle(t);
    chk("busy_clear", t - last_acc, 27);
    check_pulses();

    // Randomized back-to-back writes with held request.
    for (int k = 0; k < 16; k++) begin
      a = 1'($urandom % 2);
      if ($urandom % 4 == 0)
        d = 8'($urandom_range(0, 3));
      else
        d = 8'($urandom % 256);
      do_write(a, d, k > 0);
    end
    wait_idle(t);
    chk("b2b_last_busy", t - last_acc, last_busy);
    check_pulses();
    chk("data_retained", lcd_data, 8'(last_acc >= 0 ? lcd_data : 0));

    // Error and no-op transfers.
    chipselect = 1; read = 1; address = 1;
    #1;
    chk("rd_a1_resp", response, 2'b10);
    chk("rd_a1_data", readdata, 8'h00);
    address = 0; write = 1; writedata = 8'h41;
    #1;
    chk("rdwr_resp", response, 2'b10);
    repeat (5) @(posedge clk);
    #1;
    chk("rdwr_no_busy", waitrequest, 0);
    read = 0; byteenable = 0; writedata = 8'h55;
    #1;
    chk("be0_resp", response, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    chk("be0_no_busy", waitrequest, 0);
    chipselect = 0; write = 0; byteenable = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_pulse", mon_q.size(), 0);

    // Reset in the middle of an enable pulse.
    chipselect = 1; write = 1; address = 1;
    writedata = 8'hA5;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (lcd_en) begin
        ok = 1;
        break;
      end
    end
    chipselect = 0; write = 0;
    chk("pulse_seen", ok, 1);
    #2;
    reset = 1;
    #1;
    chk("midrst_en", lcd_en, 0);
    chk("midrst_waitreq", waitrequest, 1);
    chk("midrst_data", lcd_data, 8'h00);
    chk("midrst_rs", lcd_rs, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    r = cyc;
    mon_q.delete();
    exp_q.delete();
    run_init(r);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
